// File: rtl/mem_access_unit.sv
// Memory stage of the 5-stage RISC-V pipeline.
// Handles legality checks, lane steering, the req/ack data-memory port and the MEM/WB register.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_mem_in_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  output logic        out_stall,
  output logic        out_mem_req,
  output logic        out_mem_we,
  output logic [31:0] out_mem_addr,
  output logic [31:0] out_mem_wdata,
  output logic [3:0]  out_mem_wstrb,
  input  logic        in_mem_ack,
  input  logic [31:0] in_mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_alu_out,
  output logic [31:0] out_load_data,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        out_write_enable,
  output logic [1:0]  out_mem_exception
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg;
  logic [15:0] timeout_count_reg;
  logic [31:0] pend_alu_reg;
  logic [4:0]  pend_rd_reg;
  logic [2:0]  pend_funct3_reg;
  logic        pend_mem_to_reg_reg;
  logic        pend_write_enable_reg;
  logic        pend_load_reg;

  logic        is_mem;
  logic        load_f3_ok;
  logic        store_f3_ok;
  logic        illegal;
  logic        misaligned;
  logic [1:0]  exc_code;
  logic        start_access;
  logic        timeout_hit;
  logic [3:0]  store_wstrb;
  logic [31:0] store_wdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [7:0]  rdata_byte [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rdata_lane
      assign rdata_byte[gi] = in_mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    is_mem      = in_mem_read | in_mem_write;
    load_f3_ok  = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                  (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    store_f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    illegal     = (in_mem_read && in_mem_write) ||
                  (in_mem_read && !load_f3_ok) ||
                  (in_mem_write && !store_f3_ok);
    misaligned  = ((in_funct3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00)) ||
                  ((in_funct3[1:0] == 2'b01) && in_alu_out[0]);
    exc_code    = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
    start_access = (state_reg == IDLE) && in_valid && is_mem && (exc_code == 2'b00);
    // A timed-out access retires with an exception, so EX/MEM must advance that cycle too.
    timeout_hit = (state_reg == BUSY) && !in_mem_ack &&
                  (timeout_count_reg == 16'(TIMEOUT_CYCLES - 1));
    out_stall   = start_access || ((state_reg == BUSY) && !in_mem_ack && !timeout_hit);
  end

  always_comb begin
    store_wstrb = 4'b1111;
    store_wdata = in_mem_in_data;
    case (in_funct3[1:0])
      2'b00: begin
        store_wstrb = 4'b0001 << in_alu_out[1:0];
        store_wdata = {4{in_mem_in_data[7:0]}};
      end
      2'b01: begin
        store_wstrb = 4'b0011 << {in_alu_out[1], 1'b0};
        store_wdata = {2{in_mem_in_data[15:0]}};
      end
      default: begin
        store_wstrb = 4'b1111;
        store_wdata = in_mem_in_data;
      end
    endcase
  end

  always_comb begin
    sel_byte = rdata_byte[pend_alu_reg[1:0]];
    sel_half = pend_alu_reg[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    case (pend_funct3_reg)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'd0, sel_byte};
      3'b101:  load_ext = {16'd0, sel_half};
      default: load_ext = in_mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg             <= IDLE;
      timeout_count_reg     <= 16'd0;
      pend_alu_reg          <= 32'd0;
      pend_rd_reg           <= 5'd0;
      pend_funct3_reg       <= 3'd0;
      pend_mem_to_reg_reg   <= 1'b0;
      pend_write_enable_reg <= 1'b0;
      pend_load_reg         <= 1'b0;
      out_mem_req           <= 1'b0;
      out_mem_we            <= 1'b0;
      out_mem_addr          <= 32'd0;
      out_mem_wdata         <= 32'd0;
      out_mem_wstrb         <= 4'd0;
      out_valid             <= 1'b0;
      out_alu_out           <= 32'd0;
      out_load_data         <= 32'd0;
      out_rd                <= 5'd0;
      out_mem_to_reg        <= 1'b0;
      out_write_enable      <= 1'b0;
      out_mem_exception     <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          timeout_count_reg <= 16'd0;
          if (start_access) begin
            state_reg             <= BUSY;
            out_mem_req           <= 1'b1;
            out_mem_we            <= in_mem_write;
            out_mem_addr          <= {in_alu_out[31:2], 2'b00};
            out_mem_wdata         <= in_mem_write ? store_wdata : 32'd0;
            out_mem_wstrb         <= in_mem_write ? store_wstrb : 4'd0;
            pend_alu_reg          <= in_alu_out;
            pend_rd_reg           <= in_rd;
            pend_funct3_reg       <= in_funct3;
            pend_mem_to_reg_reg   <= in_mem_to_reg;
            pend_write_enable_reg <= in_write_enable;
            pend_load_reg         <= in_mem_read;
            out_valid             <= 1'b0;
            out_write_enable      <= 1'b0;
            out_mem_exception     <= 2'b00;
          end else if (in_valid) begin
            // Non-memory ops and rejected memory ops pass straight through.
            out_valid         <= 1'b1;
            out_alu_out       <= in_alu_out;
            out_rd            <= in_rd;
            out_mem_to_reg    <= in_mem_to_reg;
            out_load_data     <= 32'd0;
            out_write_enable  <= is_mem ? 1'b0 : in_write_enable;
            out_mem_exception <= is_mem ? exc_code : 2'b00;
          end else begin
            out_valid         <= 1'b0;
            out_write_enable  <= 1'b0;
            out_mem_exception <= 2'b00;
          end
        end
        BUSY: begin
          if (in_mem_ack || timeout_hit) begin
            state_reg         <= IDLE;
            out_mem_req       <= 1'b0;
            timeout_count_reg <= 16'd0;
            out_valid         <= 1'b1;
            out_alu_out       <= pend_alu_reg;
            out_rd            <= pend_rd_reg;
            out_mem_to_reg    <= pend_mem_to_reg_reg;
            out_load_data     <= (in_mem_ack && pend_load_reg) ? load_ext : 32'd0;
            out_write_enable  <= in_mem_ack ? pend_write_enable_reg : 1'b0;
            out_mem_exception <= in_mem_ack ? 2'b00 : 2'b10;
          end else begin
            timeout_count_reg <= timeout_count_reg + 16'd1;
            out_valid         <= 1'b0;
            out_write_enable  <= 1'b0;
            out_mem_exception <= 2'b00;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by random
// transactions compared against a byte-level reference model.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_out;
  logic [31:0] in_mem_in_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg;
  logic        in_write_enable;
  logic        out_stall;
  logic        out_mem_req;
  logic        out_mem_we;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_wdata;
  logic [3:0]  out_mem_wstrb;
  logic        in_mem_ack;
  logic [31:0] in_mem_rdata;
  logic        out_valid;
  logic [31:0] out_alu_out;
  logic [31:0] out_load_data;
  logic [4:0]  out_rd;
  logic        out_mem_to_reg;
  logic        out_write_enable;
  logic [1:0]  out_mem_exception;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_out(in_alu_out),
    .in_mem_in_data(in_mem_in_data), .in_funct3(in_funct3), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg),
    .in_write_enable(in_write_enable), .out_stall(out_stall), .out_mem_req(out_mem_req),
    .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
    .out_mem_wstrb(out_mem_wstrb), .in_mem_ack(in_mem_ack), .in_mem_rdata(in_mem_rdata),
    .out_valid(out_valid), .out_alu_out(out_alu_out), .out_load_data(out_load_data),
    .out_rd(out_rd), .out_mem_to_reg(out_mem_to_reg), .out_write_enable(out_write_enable),
    .out_mem_exception(out_mem_exception)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference legality: exception code for a memory op.
  function automatic logic [1:0] ref_exc(input logic r, input logic w, input logic [2:0] f3,
                                         input logic [31:0] a);
    int size;
    if (r && w) return 2'b11;
    if (r && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 2'b11;
    if (w && !(f3 inside {3'b000, 3'b001, 3'b010})) return 2'b11;
    size = 1 << f3[1:0];
    if ((a % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_all_zero(input string tag);
    chkb({tag, "_req"}, out_mem_req, 1'b0);
    chkb({tag, "_we"}, out_mem_we, 1'b0);
    chk({tag, "_addr"}, out_mem_addr, 32'd0);
    chk({tag, "_wdata"}, out_mem_wdata, 32'd0);
    chk({tag, "_wstrb"}, 32'(out_mem_wstrb), 32'd0);
    chkb({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_alu"}, out_alu_out, 32'd0);
    chk({tag, "_load"}, out_load_data, 32'd0);
    chk({tag, "_rd"}, 32'(out_rd), 32'd0);
    chkb({tag, "_m2r"}, out_mem_to_reg, 1'b0);
    chkb({tag, "_wen"}, out_write_enable, 1'b0);
    chk({tag, "_exc"}, 32'(out_mem_exception), 32'd0);
  endtask

  // Called at a falling edge; returns at a falling edge with the EX/MEM slot emptied.
  task automatic run_op(input logic v, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input logic m2r, input logic wen, input int ack_delay,
                        input logic [31:0] rdata);
    logic [1:0]  e_exc;
    logic        e_mem;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
    longint unsigned val, mask;
    int size, off, k, req_cycles;
    logic ack_now, e_to, done;

    e_exc = (r || w) ? ref_exc(r, w, f3, a) : 2'b00;
    e_mem = v && (r || w) && (e_exc == 2'b00);
    in_valid = v; in_mem_read = r; in_mem_write = w; in_funct3 = f3;
    in_alu_out = a; in_mem_in_data = d; in_rd = rd; in_mem_to_reg = m2r;
    in_write_enable = wen; in_mem_ack = 1'b0;
    #1;
    chkb("stall_issue", out_stall, e_mem);
    @(posedge clk); @(negedge clk);
    req_cycles = 0;
    if (!e_mem) begin
      chkb("req_none", out_mem_req, 1'b0);
      chkb("pass_valid", out_valid, v);
      chkb("pass_wen", out_write_enable, v && !(r || w) && wen);
      if (v) begin
        chk("pass_exc", 32'(out_mem_exception), 32'(e_exc));
        chk("pass_alu", out_alu_out, a);
        chk("pass_rd", 32'(out_rd), 32'(rd));
        chkb("pass_m2r", out_mem_to_reg, m2r);
        chk("pass_load", out_load_data, 32'd0);
      end
    end else begin
      size = 1 << f3[1:0];
      off = int'(a[1:0]);
      e_wstrb = 4'd0;
      e_wdata = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (w && i >= off && i < off + size) e_wstrb[i] = 1'b1;
        if (w) e_wdata[8*i +: 8] = d[8*(i % size) +: 8];
      end
      val = longint'(rdata) >> (8 * off);
      mask = (64'd1 << (8 * size)) - 64'd1;
      val = val & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      e_load = val[31:0];
      chkb("busy_valid", out_valid, 1'b0);
      chkb("busy_wen", out_write_enable, 1'b0);
      chkb("mem_we", out_mem_we, w);
      chk("mem_wstrb", 32'(out_mem_wstrb), 32'(e_wstrb));
      if (w) chk("mem_wdata", out_mem_wdata, e_wdata);
      done = 1'b0;
      k = 0;
      while (!done) begin
        ack_now = (k == ack_delay);
        e_to = !ack_now && (k + 1 == TMO);
        in_mem_ack = ack_now;
        in_mem_rdata = ack_now ? rdata : $urandom;
        #1;
        chkb("req_busy", out_mem_req, 1'b1);
        chk("addr_held", out_mem_addr, {a[31:2], 2'b00});
        chkb("stall_busy", out_stall, !(ack_now || e_to));
        req_cycles++;
        @(posedge clk); @(negedge clk);
        in_mem_ack = 1'b0;
        if (ack_now || e_to) done = 1'b1;
        else begin
          chkb("wait_bubble", out_valid, 1'b0);
          k++;
        end
      end
      chkb("done_req", out_mem_req, 1'b0);
      chkb("done_valid", out_valid, 1'b1);
      chk("done_exc", 32'(out_mem_exception), ack_now ? 32'd0 : 32'd2);
      chkb("done_wen", out_write_enable, ack_now && wen);
      chk("done_alu", out_alu_out, a);
      chk("done_rd", 32'(out_rd), 32'(rd));
      chkb("done_m2r", out_mem_to_reg, m2r);
      chk("done_load", out_load_data, (ack_now && r) ? e_load : 32'd0);
    end
    $display("op v=%0d r=%0d w=%0d f3=%0d addr=%h data=%h exc=%0d req_cycles=%0d load=%h",
             v, r, w, f3, a, d, out_mem_exception, req_cycles, out_load_data);
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
  endtask

  initial begin
    int mode, dly;
    logic r, w, v;
    reset = 1'b0;
    in_valid = 1'b0; in_alu_out = 32'd0; in_mem_in_data = 32'd0; in_funct3 = 3'd0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_rd = 5'd0; in_mem_to_reg = 1'b0;
    in_write_enable = 1'b0; in_mem_ack = 1'b0; in_mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    chkb("reset_stall", out_stall, 1'b0);
    reset = 1'b1;

    run_op(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 2, 32'd0);
    run_op(1, 1, 0, 3'b000, 32'h203, 32'd0, 5'd7, 1, 1, 0, 32'h80FF_00AA);
    run_op(1, 1, 0, 3'b100, 32'h203, 32'd0, 5'd7, 1, 1, 0, 32'h80FF_00AA);
    run_op(1, 1, 0, 3'b001, 32'h202, 32'd0, 5'd8, 1, 1, 1, 32'h80FF_00AA);
    run_op(1, 0, 1, 3'b000, 32'h11, 32'h123456AB, 5'd0, 0, 0, 0, 32'd0);
    run_op(1, 0, 1, 3'b001, 32'h13, 32'h123456AB, 5'd0, 0, 0, 0, 32'd0);
    run_op(1, 0, 0, 3'b000, 32'h5, 32'd0, 5'd3, 0, 1, 0, 32'd0);
    run_op(1, 1, 0, 3'b010, 32'h40, 32'd0, 5'd4, 1, 1, 0, 32'h1122_3344);
    run_op(1, 1, 0, 3'b010, 32'h44, 32'd0, 5'd5, 1, 1, 0, 32'h5566_7788);
    run_op(1, 1, 0, 3'b010, 32'h80, 32'd0, 5'd6, 1, 1, -1, 32'd0);

    // Reset while an access is outstanding, then a stray ack in IDLE.
    in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010; in_alu_out = 32'h300;
    in_rd = 5'd9; in_mem_to_reg = 1'b1; in_write_enable = 1'b1;
    @(posedge clk); @(negedge clk);
    chkb("rst_busy_req", out_mem_req, 1'b1);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all_zero("rst_mid");
    reset = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0;
    in_mem_ack = 1'b1; in_mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    chkb("stray_ack_valid", out_valid, 1'b0);
    chkb("stray_ack_req", out_mem_req, 1'b0);
    chk("stray_ack_load", out_load_data, 32'd0);
    in_mem_ack = 1'b0;
    $display("op reset-mid-busy with stray ack valid=%0d", out_valid);

    for (int n = 0; n < 200; n++) begin
      mode = $urandom_range(0, 9);
      v = (mode != 0);
      r = (mode == 1) || (mode >= 4 && mode <= 6) || (mode == 0 && $urandom_range(0, 1) == 1);
      w = (mode == 1) || (mode >= 7);
      dly = ($urandom_range(0, 5) == 5) ? -1 : int'($urandom_range(0, 2));
      run_op(v, r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
             1'($urandom), 1'($urandom), dly, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
